// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the sequential FP add/subtract units:
// field widths, special encodings, FSM state encoding and flag bit positions.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int EXT_W  = MANT_W + 3;
  localparam int EW     = 10;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ADDSUB = 3'd3,
    NORM   = 3'd4,
    ROUND  = 3'd5,
    DONE   = 3'd6
  } state_t;
endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an FP32 word into sign/exponent/mantissa with class detection.
// Denormals are treated as signed zero when FTZ is set.
module fp_unpack
  import fp_pkg::*;
#(
  parameter bit FTZ = 1
) (
  input  logic [31:0]       f,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] man,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);
  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_max;

  assign sign     = f[31];
  assign exp      = f[30:23];
  assign frac     = f[22:0];
  assign exp_zero = (exp == '0);
  assign exp_max  = (exp == '1);

  assign man     = {~exp_zero, (FTZ && exp_zero) ? '0 : frac};
  assign is_zero = exp_zero;
  assign is_inf  = exp_max && (frac == '0);
  assign is_nan  = exp_max && (frac != '0);
endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle FP32 subtractor (a - b): b's sign is flipped on capture, then an
// iterative align / add / normalise / RNE round datapath produces the result.
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int MAX_ALIGN = 26,
  parameter bit FTZ       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  state_t state;
  logic [31:0] a_reg, b_reg;
  logic sx, sy;
  logic signed [EW-1:0] ex;
  logic [EW-1:0] diff;
  logic [EXT_W-1:0] mx, my;
  logic [EXT_W:0] m;
  logic signed [EW-1:0] e;

  logic ua_s, ua_z, ua_i, ua_n, ub_s, ub_z, ub_i, ub_n;
  logic [EXP_W-1:0] ua_e, ub_e;
  logic [MANT_W-1:0] ua_m, ub_m;

  fp_unpack #(.FTZ(FTZ)) u_unpack_a (
    .f(a_reg), .sign(ua_s), .exp(ua_e), .man(ua_m),
    .is_zero(ua_z), .is_inf(ua_i), .is_nan(ua_n)
  );
  fp_unpack #(.FTZ(FTZ)) u_unpack_b (
    .f(b_reg), .sign(ub_s), .exp(ub_e), .man(ub_m),
    .is_zero(ub_z), .is_inf(ub_i), .is_nan(ub_n)
  );

  // Magnitude order decides which operand stays unshifted (X).
  logic [30:0] mag_a, mag_b;
  logic swap;
  logic [EW-1:0] diff_c;
  assign mag_a  = ua_z ? '0 : {ua_e, ua_m[FRAC_W-1:0]};
  assign mag_b  = ub_z ? '0 : {ub_e, ub_m[FRAC_W-1:0]};
  assign swap   = (mag_b > mag_a);
  assign diff_c = swap ? ({2'b00, ub_e} - {2'b00, ua_e}) : ({2'b00, ua_e} - {2'b00, ub_e});

  logic [EXT_W:0] sum_c;
  assign sum_c = (sx == sy) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});

  logic g_bit, r_bit, s_bit, inc;
  logic [MANT_W:0] rm;
  logic signed [EW-1:0] e_r;
  assign g_bit = m[2];
  assign r_bit = m[1];
  assign s_bit = m[0];
  assign inc   = g_bit & (r_bit | s_bit | m[3]);
  assign rm    = {1'b0, m[EXT_W-1:3]} + {{MANT_W{1'b0}}, inc};
  assign e_r   = rm[MANT_W] ? e + 10'sd1 : e;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sx        <= 1'b0;
      sy        <= 1'b0;
      ex        <= '0;
      diff      <= '0;
      mx        <= '0;
      my        <= '0;
      m         <= '0;
      e         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg    <= a;
          b_reg    <= {~b[31], b[30:0]};
          in_ready <= 1'b0;
          state    <= UNPACK;
        end
        UNPACK: begin
          if (ua_n || ub_n || (ua_i && ub_i && (ua_s != ub_s))) begin
            result    <= QNAN;
            flags     <= 4'b1 << FLAG_INVALID;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (ua_i || ub_i) begin
            result    <= (ua_i ? ua_s : ub_s) ? NEG_INF : POS_INF;
            flags     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sx    <= swap ? ub_s : ua_s;
            sy    <= swap ? ua_s : ub_s;
            ex    <= $signed({2'b00, swap ? ub_e : ua_e});
            mx    <= {swap ? ub_m : ua_m, 3'b000};
            my    <= {swap ? ua_m : ub_m, 3'b000};
            diff  <= diff_c;
            state <= (diff_c == '0) ? ADDSUB : ALIGN;
          end
        end
        ALIGN: begin
          if (diff > EW'(MAX_ALIGN)) begin
            my    <= {{(EXT_W-1){1'b0}}, |my};
            state <= ADDSUB;
          end else begin
            my    <= {1'b0, my[EXT_W-1:2], my[1] | my[0]};
            diff  <= diff - 10'd1;
            if (diff == 10'd1) state <= ADDSUB;
          end
        end
        ADDSUB: begin
          if (sum_c == '0) begin
            // Only like-signed zeros keep their sign; true cancellation gives +0.
            result    <= {(sx == sy) ? sx : 1'b0, 31'b0};
            flags     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            m     <= sum_c;
            e     <= ex;
            state <= NORM;
          end
        end
        NORM: begin
          if (m[EXT_W]) begin
            m <= {1'b0, m[EXT_W:2], m[1] | m[0]};
            e <= e + 10'sd1;
          end else if (m[EXT_W-1]) begin
            state <= ROUND;
          end else if (e <= 10'sd1) begin
            result    <= {sx, 31'b0};
            flags     <= (4'b1 << FLAG_UNDERFLOW) | (4'b1 << FLAG_INEXACT);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            m <= {m[EXT_W-1:0], 1'b0};
            e <= e - 10'sd1;
          end
        end
        ROUND: begin
          if (e_r >= 10'sd255) begin
            result <= sx ? NEG_INF : POS_INF;
            flags  <= (4'b1 << FLAG_OVERFLOW) | (4'b1 << FLAG_INEXACT);
          end else begin
            result <= {sx, e_r[EXP_W-1:0], rm[MANT_W] ? 23'b0 : rm[FRAC_W-1:0]};
            flags  <= {3'b000, g_bit | r_bit | s_bit};
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed scoreboard bench for fp_subtractor_seq: each operation pushes its expected
// result/flags, and the popped entry is checked when the DUT presents its output.
module tb_fp_subtractor_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];

  fp_subtractor_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
    compared++;
    assert (got === want) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic send(input logic [31:0] op_a, input logic [31:0] op_b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] want_res, input logic [3:0] want_flg,
                        input int stall);
    exp_t ex;
    int n = 0;
    sb.push_back({want_res, want_flg});
    send(op_a, op_b);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check32("out_valid_wait", {31'b0, out_valid}, 32'd1);
    ex = sb.pop_front();
    for (int i = 0; i < stall; i++) begin
      check32("stall_result", result, ex.res);
      check32("stall_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
    end
    check32("result", result, ex.res);
    check32("flags", {28'b0, flags}, {28'b0, ex.flg});
    $display("txn a=%h b=%h result=%h flags=%b want=%h/%b", op_a, op_b, result, flags,
             ex.res, ex.flg);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check32("out_valid_drop", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check32("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check32("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check32("rst_result", result, 32'h0);
    check32("rst_flags", {28'b0, flags}, 32'h0);
    rst_n = 1'b1;

    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 0); // 3 - 1
    run_op(32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 0); // 1 - 1
    run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 4'b0000, 0); // 1 - (-1)
    run_op(32'h3F800000, 32'h30800000, 32'h3F800000, 4'b0001, 0); // 1 - 2^-30
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 0); // inf - inf
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0); // NaN
    run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4'b0101, 0); // overflow
    run_op(32'h40000000, 32'h40400000, 32'hBF800000, 4'b0000, 0); // 2 - 3
    run_op(32'h3FC00000, 32'h3E800000, 32'h3FA00000, 4'b0000, 0); // 1.5 - 0.25
    run_op(32'h3F800000, 32'hB3800000, 32'h3F800000, 4'b0001, 0); // tie to even, down
    run_op(32'h3F800001, 32'hB3800000, 32'h3F800002, 4'b0001, 0); // tie to even, up
    run_op(32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011, 0); // underflow flush
    run_op(32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 0); // -0 - +0
    run_op(32'h3F800000, 32'h00400000, 32'h3F800000, 4'b0000, 0); // denormal flushed
    run_op(32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 0); // -inf - 1
    run_op(32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000, 0); // 1 - inf
    run_op(32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 10); // held in DONE

    // Reset while aligning a 20-bit exponent gap; the op must vanish.
    send(32'h3F800000, 32'h35800000);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check32("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check32("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (30) @(negedge clk);
    check32("midrst_no_output", {31'b0, out_valid}, 32'd0);
    run_op(32'h3FC00000, 32'h3E800000, 32'h3FA00000, 4'b0000, 0);

    check32("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
